scsi_periph_port: RTL and testbench

SCSI_PERIPH_PORT -- requirements
Module: scsi_periph_port

---
 rtl/scsi_periph_port_pkg.sv | 26 ++
 rtl/sync_fifo16.sv | 59 +++++
 rtl/scsi_periph_port.sv | 168 ++++++++++++++++
 tb/tb_scsi_periph_port.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scsi_periph_port_pkg.sv
// Shared constants, FSM state type and address helper for the SCSI peripheral port.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package scsi_periph_port_pkg;

    localparam int         FIFO_DEPTH   = 8;
    localparam int         REG_COUNT    = 15;
    localparam logic [3:0] FIFO_IDX     = 4'hF;

    // Status register bit positions (bit 0 always reads 0)
    localparam int         ST_BIT_EMPTY = 1;
    localparam int         ST_BIT_FULL  = 2;
    localparam int         ST_BIT_OVR   = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_e;

    // Register index auto-increment: 0xE wraps to 0x0; 0xF is handled by the caller
    function automatic logic [3:0] next_addr(input logic [3:0] a);
        return (a == FIFO_IDX - 4'h1) ? 4'h0 : a + 4'h1;
    endfunction

endpackage

// File: rtl/sync_fifo16.sv
// 8-deep 16-bit synchronous FIFO with occupancy count and show-ahead head word.
// Latency: a pushed word is visible on dout_o the cycle after the push when the FIFO was empty.
// Backpressure: push while full is dropped unless a pop lands in the same cycle; pop while empty is ignored.
module sync_fifo16
    import scsi_periph_port_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic [15:0] din_i,
    output logic [15:0] dout_o,
    output logic        full_o,
    output logic        empty_o,
    output logic [3:0]  count_o
);

    localparam int PW = $clog2(FIFO_DEPTH);

    logic [15:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [3:0]    count_q;
    logic          push_ok;
    logic          pop_ok;

    assign empty_o = (count_q == 4'd0);
    assign full_o  = (count_q == 4'(FIFO_DEPTH));
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];
    assign pop_ok  = pop_i && !empty_o;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign push_ok = push_i && (!full_o || pop_ok);

    // Storage array; written only on an accepted push
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= 4'd0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 4'd1;
                2'b01:   count_q <= count_q - 4'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/scsi_periph_port.sv
// Asynchronous-strobe peripheral port: address/status + data registers, 15 regs and a push FIFO at index 0xF.
// Latency: read data on P_DATA 3 CLK after _IOR falls; a write commits 3 CLK after _IOW rises.
// Backpressure: none toward the host; FIFO pushes while full are dropped and raise the sticky INT flag.
module scsi_periph_port
    import scsi_periph_port_pkg::*;
(
    input  logic        CLK,
    input  logic        _RST,
    input  logic        _CS,
    input  logic        A0,
    input  logic        _IOR,
    input  logic        _IOW,
    inout  wire  [15:0] P_DATA,
    output logic        CMD_VALID,
    output logic [3:0]  CMD_ADDR,
    output logic [15:0] CMD_DATA,
    input  logic        FIFO_POP,
    output logic [15:0] FIFO_DOUT,
    output logic        FIFO_EMPTY,
    output logic        INT
);

    logic        cs_s1_q, cs_s2_q, ior_s1_q, ior_s2_q, iow_s1_q, iow_s2_q;
    logic [1:0]  sync_fill_q;
    logic        armed_q;
    state_e      state_q;
    logic [3:0]  addr_q;
    logic [15:0] regs_q [REG_COUNT];
    logic [15:0] rd_latch_q;
    logic        rd_a0_q;
    logic [15:0] wr_sample_q;
    logic        wr_a0_q;
    logic        ovr_q;
    logic        cmd_valid_q;
    logic [3:0]  cmd_addr_q;
    logic [15:0] cmd_data_q;
    logic        fifo_full;
    logic        fifo_empty;
    logic [3:0]  fifo_count;
    logic        wr_commit_d;
    logic        fifo_push_d;
    logic [15:0] rd_value_d;

    assign CMD_VALID  = cmd_valid_q;
    assign CMD_ADDR   = cmd_addr_q;
    assign CMD_DATA   = cmd_data_q;
    assign FIFO_EMPTY = fifo_empty;
    assign INT        = ovr_q;
    // Bus is driven straight from the raw strobes so it releases as soon as the host lets go
    assign P_DATA     = (!_CS && !_IOR) ? rd_latch_q : 16'hzzzz;

    assign wr_commit_d = (state_q == ST_WR) && iow_s2_q;
    assign fifo_push_d = wr_commit_d && wr_a0_q && (addr_q == FIFO_IDX);

    // Two-flop synchronizers; sync_fill_q marks when stage 2 holds real samples
    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST) begin
            {cs_s1_q, cs_s2_q}   <= 2'b11;
            {ior_s1_q, ior_s2_q} <= 2'b11;
            {iow_s1_q, iow_s2_q} <= 2'b11;
            sync_fill_q          <= 2'b00;
        end else begin
            {cs_s1_q, cs_s2_q}   <= {_CS, cs_s1_q};
            {ior_s1_q, ior_s2_q} <= {_IOR, ior_s1_q};
            {iow_s1_q, iow_s2_q} <= {_IOW, iow_s1_q};
            sync_fill_q          <= {sync_fill_q[0], 1'b1};
        end
    end

    // Value the read latch captures: status, FIFO count or indexed register
    always_comb begin
        rd_value_d = 16'h0000;
        if (!A0) begin
            rd_value_d[ST_BIT_EMPTY] = fifo_empty;
            rd_value_d[ST_BIT_FULL]  = fifo_full;
            rd_value_d[ST_BIT_OVR]   = ovr_q;
        end else if (addr_q == FIFO_IDX) begin
            rd_value_d = {12'h000, fifo_count};
        end else begin
            rd_value_d = regs_q[addr_q];
        end
    end

    // Strobe FSM with all register-file side effects. A strobe still low when reset
    // releases must not look like a new falling edge, so accesses wait until both
    // synchronized strobes have been seen high (armed_q).
    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST) begin
            state_q     <= ST_IDLE;
            armed_q     <= 1'b0;
            addr_q      <= 4'h0;
            rd_latch_q  <= 16'h0000;
            rd_a0_q     <= 1'b0;
            wr_sample_q <= 16'h0000;
            wr_a0_q     <= 1'b0;
            ovr_q       <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_addr_q  <= 4'h0;
            cmd_data_q  <= 16'h0000;
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= 16'h0000;
            end
        end else begin
            cmd_valid_q <= 1'b0;
            if (sync_fill_q[1] && ior_s2_q && iow_s2_q) begin
                armed_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (armed_q && !cs_s2_q) begin
                        if (!iow_s2_q) begin
                            state_q     <= ST_WR;
                            wr_sample_q <= P_DATA;
                            wr_a0_q     <= A0;
                        end else if (!ior_s2_q) begin
                            state_q    <= ST_RD;
                            rd_latch_q <= rd_value_d;
                            rd_a0_q    <= A0;
                        end
                    end
                end
                ST_RD: begin
                    if (ior_s2_q) begin
                        state_q <= ST_IDLE;
                        if (!rd_a0_q) begin
                            ovr_q <= 1'b0;
                        end else if (addr_q != FIFO_IDX) begin
                            addr_q <= next_addr(addr_q);
                        end
                    end
                end
                ST_WR: begin
                    if (!iow_s2_q) begin
                        wr_sample_q <= P_DATA;
                        wr_a0_q     <= A0;
                    end else begin
                        state_q <= ST_IDLE;
                        if (!wr_a0_q) begin
                            addr_q <= wr_sample_q[3:0];
                        end else if (addr_q == FIFO_IDX) begin
                            if (fifo_full && !FIFO_POP) ovr_q <= 1'b1;
                        end else begin
                            regs_q[addr_q] <= wr_sample_q;
                            cmd_valid_q    <= 1'b1;
                            cmd_addr_q     <= addr_q;
                            cmd_data_q     <= wr_sample_q;
                            addr_q         <= next_addr(addr_q);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    sync_fifo16 u_fifo (
        .clk_i   (CLK),
        .rst_ni  (_RST),
        .push_i  (fifo_push_d),
        .pop_i   (FIFO_POP),
        .din_i   (wr_sample_q),
        .dout_o  (FIFO_DOUT),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

endmodule

// File: tb/tb_scsi_periph_port.sv
// Scoreboard bench for scsi_periph_port: host bus tasks update a queue-based reference model.
// Latency: expectations are popped by a negedge monitor whenever the DUT presents a result.
// Backpressure: n/a.
module tb_scsi_periph_port;

    logic        clk;
    logic        rst_n;
    logic        cs_n;
    logic        a0;
    logic        ior_n;
    logic        iow_n;
    wire  [15:0] p_data;
    logic [15:0] drv_dat;
    logic        drv_en;
    logic        cmd_valid;
    logic [3:0]  cmd_addr;
    logic [15:0] cmd_data;
    logic        fifo_pop;
    logic [15:0] fifo_dout;
    logic        fifo_empty;
    logic        int_o;

    assign p_data = drv_en ? drv_dat : 16'hzzzz;

    scsi_periph_port dut (
        .CLK        (clk),
        ._RST       (rst_n),
        ._CS        (cs_n),
        .A0         (a0),
        ._IOR       (ior_n),
        ._IOW       (iow_n),
        .P_DATA     (p_data),
        .CMD_VALID  (cmd_valid),
        .CMD_ADDR   (cmd_addr),
        .CMD_DATA   (cmd_data),
        .FIFO_POP   (fifo_pop),
        .FIFO_DOUT  (fifo_dout),
        .FIFO_EMPTY (fifo_empty),
        .INT        (int_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: register index, register file, FIFO contents, overrun flag
    logic [3:0]  m_addr;
    logic [15:0] m_reg [15];
    logic [15:0] m_fifo [$];
    logic        m_ovr;

    // Scoreboard queues
    logic [19:0] exp_cmd [$];
    logic [15:0] exp_rd  [$];
    logic [15:0] exp_pop [$];
    logic        rd_chk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic model_reset();
        m_addr = 4'h0;
        m_ovr  = 1'b0;
        m_fifo.delete();
        for (int i = 0; i < 15; i++) m_reg[i] = 16'h0000;
    endtask

    // Host register write; optionally pulse FIFO_POP in the exact commit cycle
    task automatic bus_write(input logic a0v, input logic [15:0] data, input logic pop_commit);
        if (!a0v) begin
            m_addr = data[3:0];
        end else if (m_addr == 4'hF) begin
            if (pop_commit && m_fifo.size() > 0) begin
                exp_pop.push_back(m_fifo[0]);
                void'(m_fifo.pop_front());
            end
            if (m_fifo.size() < 8) m_fifo.push_back(data);
            else m_ovr = 1'b1;
        end else begin
            m_reg[m_addr] = data;
            exp_cmd.push_back({m_addr, data});
            m_addr = (m_addr == 4'hE) ? 4'h0 : m_addr + 4'h1;
        end
        a0 = a0v; drv_dat = data; drv_en = 1'b1;
        tick();
        cs_n = 1'b0;
        tick();
        iow_n = 1'b0;
        ticks(4);
        iow_n = 1'b1;
        ticks(2);
        if (pop_commit) fifo_pop = 1'b1;
        tick();
        fifo_pop = 1'b0;
        ticks(2);
        cs_n = 1'b1; drv_en = 1'b0;
        tick();
    endtask

    // Host register read; the bus is checked exactly 3 CLK after _IOR falls
    task automatic bus_read(input logic a0v);
        logic [15:0] e;
        e = 16'h0000;
        if (!a0v) begin
            e[3] = m_ovr;
            e[2] = (m_fifo.size() == 8);
            e[1] = (m_fifo.size() == 0);
            m_ovr = 1'b0;
        end else if (m_addr == 4'hF) begin
            e = 16'(m_fifo.size());
        end else begin
            e = m_reg[m_addr];
            m_addr = (m_addr == 4'hE) ? 4'h0 : m_addr + 4'h1;
        end
        exp_rd.push_back(e);
        a0 = a0v;
        tick();
        cs_n = 1'b0;
        tick();
        ior_n = 1'b0;
        ticks(3);
        rd_chk = 1'b1;
        tick();
        rd_chk = 1'b0;
        ior_n = 1'b1;
        ticks(4);
        cs_n = 1'b1;
        tick();
    endtask

    task automatic core_pop();
        if (m_fifo.size() > 0) begin
            exp_pop.push_back(m_fifo[0]);
            void'(m_fifo.pop_front());
        end
        fifo_pop = 1'b1;
        tick();
        fifo_pop = 1'b0;
        tick();
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_fifo_empty"}, 32'(fifo_empty), 32'(m_fifo.size() == 0));
        check({tag, "_int"}, 32'(int_o), 32'(m_ovr));
        if (m_fifo.size() > 0) check({tag, "_fifo_dout"}, 32'(fifo_dout), 32'(m_fifo[0]));
    endtask

    // Monitor: pops expectations whenever the DUT presents a command, read data or FIFO head
    always @(negedge clk) begin
        if (cmd_valid === 1'b1) begin
            if (exp_cmd.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_cmd actual=%h:%h required=none", cmd_addr, cmd_data);
            end else begin
                check("cmd_addr_data", 32'({cmd_addr, cmd_data}), 32'(exp_cmd.pop_front()));
            end
        end
        if (rd_chk) begin
            if (exp_rd.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_read actual=%h required=none", p_data);
            end else begin
                check("rd_data", 32'(p_data), 32'(exp_rd.pop_front()));
            end
        end
        if (fifo_pop && !fifo_empty) begin
            if (exp_pop.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_pop actual=%h required=empty", fifo_dout);
            end else begin
                check("pop_head", 32'(fifo_dout), 32'(exp_pop.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cs_n = 1'b1; a0 = 1'b0; ior_n = 1'b1; iow_n = 1'b1;
        drv_dat = 16'h0000; drv_en = 1'b0; fifo_pop = 1'b0; rd_chk = 1'b0;
        model_reset();
        ticks(3);
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_cmd_addr", 32'(cmd_addr), 32'd0);
        check("rst_cmd_data", 32'(cmd_data), 32'd0);
        check_outputs("rst");
        rst_n = 1'b1;
        ticks(4);

        // Address load then two data writes with auto-increment
        bus_write(1'b0, 16'h0003, 1'b0);
        bus_write(1'b1, 16'h1234, 1'b0);
        bus_write(1'b1, 16'h5678, 1'b0);
        bus_write(1'b1, 16'h9ABC, 1'b0);   // lands at index 5
        bus_write(1'b0, 16'h0003, 1'b0);
        bus_read(1'b1);
        bus_read(1'b1);

        // Wrap from 0xE to 0x0
        bus_write(1'b0, 16'h000E, 1'b0);
        bus_write(1'b1, 16'hAAAA, 1'b0);
        bus_write(1'b1, 16'hBBBB, 1'b0);
        bus_write(1'b0, 16'h000E, 1'b0);
        bus_read(1'b1);
        bus_read(1'b1);

        // FIFO overflow, sticky INT and clear-on-status-read
        bus_write(1'b0, 16'h000F, 1'b0);
        for (int i = 1; i <= 9; i++) bus_write(1'b1, 16'(i), 1'b0);
        check_outputs("ovf");
        bus_read(1'b0);
        check_outputs("ovr_clr");
        bus_read(1'b0);
        bus_read(1'b1);

        // Push and pop in the same cycle while full
        bus_write(1'b1, 16'h00A0, 1'b1);
        check_outputs("push_pop_full");
        bus_read(1'b1);
        bus_read(1'b0);

        // Drain past empty
        for (int i = 0; i < 9; i++) core_pop();
        check_outputs("drained");
        bus_read(1'b0);

        // _IOR with _CS high: bus must stay released and nothing may change
        drv_dat = 16'h0000; drv_en = 1'b1;
        ior_n = 1'b0;
        ticks(5);
        check("hiz_cs_high", 32'(p_data), 32'h0);
        ior_n = 1'b1; drv_en = 1'b0;
        ticks(4);
        bus_read(1'b0);
        bus_read(1'b1);

        // Randomized traffic against the model
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 5))
                0: bus_write(1'b0, ($urandom_range(0, 2) == 0) ? 16'h000F : 16'($urandom), 1'b0);
                1, 2: bus_write(1'b1, 16'($urandom), 1'($urandom_range(0, 1)));
                3: bus_read(1'b0);
                4: bus_read(1'b1);
                default: core_pop();
            endcase
            check_outputs("rand");
        end

        // Reset in the middle of a write: nothing may commit afterwards
        bus_write(1'b0, 16'h0002, 1'b0);
        a0 = 1'b1; drv_dat = 16'hDEAD; drv_en = 1'b1;
        tick();
        cs_n = 1'b0;
        tick();
        iow_n = 1'b0;
        ticks(4);
        rst_n = 1'b0;
        model_reset();
        ticks(2);
        rst_n = 1'b1;
        ticks(3);
        iow_n = 1'b1;
        ticks(6);
        cs_n = 1'b1; drv_en = 1'b0;
        tick();
        check("midrst_cmd_addr", 32'(cmd_addr), 32'd0);
        check("midrst_cmd_data", 32'(cmd_data), 32'd0);
        check_outputs("midrst");
        bus_read(1'b0);
        bus_read(1'b1);
        bus_write(1'b1, 16'h4321, 1'b0);

        ticks(4);
        check("cmd_q_drained", 32'(exp_cmd.size()), 32'd0);
        check("rd_q_drained", 32'(exp_rd.size()), 32'd0);
        check("pop_q_drained", 32'(exp_pop.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
